// File: rtl/g5_apblink_pkg.sv
// Shared constants and types for the APBLink requester arbiter.
package g5_apblink_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    // One requester's command payload as forwarded downstream.
    typedef struct packed {
        logic              write;
        logic [STRB_W-1:0] strb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_cmd_t;

    // True whenever a downstream transfer is owned by some requester.
    function automatic logic is_active(state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/g5_apblink_arb_if.sv
// Bus bundle between the requesters, the arbiter and the APBLink master.
// slave: the arbiter's view. master: the surrounding system's view.
interface g5_apblink_arb_if #(parameter int NREQ = 2);
    import g5_apblink_pkg::*;

    // Requester side, packed per requester (requester i in slice i).
    logic [NREQ-1:0]        s_psel;
    logic [NREQ-1:0]        s_penable;
    logic [NREQ-1:0]        s_pwrite;
    logic [STRB_W*NREQ-1:0] s_pstrb;
    logic [ADDR_W*NREQ-1:0] s_paddr;
    logic [DATA_W*NREQ-1:0] s_pwdata;
    logic [DATA_W*NREQ-1:0] s_prdata;
    logic [NREQ-1:0]        s_pready;
    logic [NREQ-1:0]        s_pslverr;

    // Downstream side toward the APBLink master.
    logic                   m_psel;
    logic                   m_penable;
    logic                   m_pwrite;
    logic [STRB_W-1:0]      m_pstrb;
    logic [ADDR_W-1:0]      m_paddr;
    logic [DATA_W-1:0]      m_pwdata;
    logic [DATA_W-1:0]      m_prdata;
    logic                   m_pready;
    logic                   m_pslverr;

    modport slave (
        input  s_psel, s_penable, s_pwrite, s_pstrb, s_paddr, s_pwdata,
        output s_prdata, s_pready, s_pslverr,
        output m_psel, m_penable, m_pwrite, m_pstrb, m_paddr, m_pwdata,
        input  m_prdata, m_pready, m_pslverr
    );

    modport master (
        output s_psel, s_penable, s_pwrite, s_pstrb, s_paddr, s_pwdata,
        input  s_prdata, s_pready, s_pslverr,
        input  m_psel, m_penable, m_pwrite, m_pstrb, m_paddr, m_pwdata,
        output m_prdata, m_pready, m_pslverr
    );

endinterface

// File: rtl/g5_apblink_arb_rr.sv
// Combinational round-robin picker: the first requester found when searching
// upward from (last + 1) mod NREQ wins; the result is one-hot or zero.
module g5_rr_arb #(
    parameter int  NREQ  = 2,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  winner
);

    logic found;

    // Walk the candidates in priority order and keep the first requester.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == (int'(last) + k) % NREQ)) begin
                    winner[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/g5_apblink_arb.sv
// Arbitrates NREQ APB requesters onto one APBLink master port with
// round-robin fairness and an ACCESS-phase timeout that answers the
// requester with an error and then drains the stuck downstream transfer.
module g5_apblink_arb
    import g5_apblink_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             pclk,
    input  logic             preset_b,
    g5_apblink_arb_if.slave  bus,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic             to_pulse
);

    localparam int                IDX_W    = $clog2(NREQ);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   winner;
    logic [IDX_W-1:0]  winner_idx;
    apb_cmd_t          cmd;
    logic              tmo_hit;
    logic              s_penable_unused;

    // Requester-side PENABLE carries no information the arbiter needs.
    assign s_penable_unused = ^bus.s_penable;

    g5_rr_arb #(.NREQ(NREQ)) u_rr (
        .req    (bus.s_psel),
        .last   (last_q),
        .winner (winner)
    );

    // Convert the one-hot winner into the index remembered as last winner.
    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner[i]) winner_idx = IDX_W'(i);
        end
    end

    // Select the granted requester's payload (zero when nobody is granted).
    always_comb begin
        cmd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                cmd.write = cmd.write | bus.s_pwrite[i];
                cmd.strb  = cmd.strb  | bus.s_pstrb[i*STRB_W +: STRB_W];
                cmd.addr  = cmd.addr  | bus.s_paddr[i*ADDR_W +: ADDR_W];
                cmd.wdata = cmd.wdata | bus.s_pwdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign tmo_hit = (cnt_q == CNT_LAST);

    // State, grant, last winner and ACCESS cycle counter registers.
    always_ff @(posedge pclk or negedge preset_b) begin
        if (!preset_b) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count in ACCESS, wait out DRAIN.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                cnt_d   = '0;
                if (|bus.s_psel) begin
                    grant_d = winner;
                    last_d  = winner_idx;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // A ready in the timeout cycle is a normal completion.
                if (bus.m_pready) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (tmo_hit) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.m_pready) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Downstream drive and the granted requester's completion response.
    always_comb begin
        bus.m_psel    = 1'b0;
        bus.m_penable = 1'b0;
        bus.m_pwrite  = 1'b0;
        bus.m_pstrb   = '0;
        bus.m_paddr   = '0;
        bus.m_pwdata  = '0;
        bus.s_pready  = '0;
        bus.s_pslverr = '0;
        bus.s_prdata  = '0;
        to_pulse      = 1'b0;

        if (is_active(state_q)) begin
            bus.m_psel    = 1'b1;
            bus.m_penable = (state_q == ST_ACCESS) || (state_q == ST_DRAIN);
            bus.m_pwrite  = cmd.write;
            bus.m_pstrb   = cmd.strb;
            bus.m_paddr   = cmd.addr;
            bus.m_pwdata  = cmd.wdata;
        end

        // DRAIN answers nobody: its response was already replaced by the timeout error.
        if ((state_q == ST_ACCESS) && (bus.m_pready || tmo_hit)) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_q[i]) begin
                    bus.s_pready[i]  = 1'b1;
                    bus.s_pslverr[i] = bus.m_pready ? bus.m_pslverr : 1'b1;
                    bus.s_prdata[i*DATA_W +: DATA_W] = bus.m_pready ? bus.m_prdata : '0;
                end
            end
            to_pulse = !bus.m_pready;
        end
    end

    assign grant = grant_q;
    assign busy  = is_active(state_q);

endmodule

// File: tb/tb_g5_apblink_arb.sv
// Self-checking bench for g5_apblink_arb: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a transaction model.
module tb_g5_apblink_arb;
    import g5_apblink_pkg::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic pclk = 1'b0;
    logic preset_b;
    always #5 pclk = ~pclk;

    g5_apblink_arb_if #(.NREQ(NREQ)) bus ();
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            to_pulse;

    g5_apblink_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .pclk     (pclk),
        .preset_b (preset_b),
        .bus      (bus),
        .grant    (grant),
        .busy     (busy),
        .to_pulse (to_pulse)
    );

    // Transaction-level model state.
    int              n_checks = 0;
    int              n_fail   = 0;
    int              last_win;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] psel_drv;
    apb_cmd_t        r_cmd [NREQ];
    logic [NREQ-1:0] obs_grants [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first pending requester at or after last+1 (mod NREQ).
    function automatic int rr_pick(input logic [NREQ-1:0] p, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (p[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            bus.s_psel[i]                 = psel_drv[i];
            bus.s_penable[i]              = psel_drv[i];
            bus.s_pwrite[i]               = r_cmd[i].write;
            bus.s_pstrb[i*STRB_W +: STRB_W] = r_cmd[i].strb;
            bus.s_paddr[i*ADDR_W +: ADDR_W] = r_cmd[i].addr;
            bus.s_pwdata[i*DATA_W +: DATA_W] = r_cmd[i].wdata;
        end
    endtask

    task automatic raise_cmd(input int i, input apb_cmd_t c);
        pending[i]  = 1'b1;
        psel_drv[i] = 1'b1;
        r_cmd[i]    = c;
        apply();
    endtask

    // New random requests from every requester in mask that is not already waiting.
    task automatic raise(input logic [NREQ-1:0] mask);
        apb_cmd_t c;
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i] && !pending[i]) begin
                c.write = 1'($urandom);
                c.strb  = STRB_W'($urandom);
                c.addr  = ADDR_W'($urandom);
                c.wdata = $urandom;
                raise_cmd(i, c);
            end
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Compare every DUT output with what the model expects this cycle.
    task automatic chk_bus(input string ph, input int g, input logic pen, input logic resp,
                           input logic err, input logic [31:0] rd, input logic to);
        logic [NREQ-1:0]        e_grant, e_rdy, e_err;
        logic [NREQ*DATA_W-1:0] e_rd;
        apb_cmd_t               e_cmd;
        e_grant = '0;
        e_rdy   = '0;
        e_err   = '0;
        e_rd    = '0;
        e_cmd   = '0;
        if (g >= 0) begin
            e_grant[g] = 1'b1;
            e_cmd      = r_cmd[g];
            if (resp) begin
                e_rdy[g] = 1'b1;
                e_err[g] = err;
                e_rd[g*DATA_W +: DATA_W] = rd;
            end
        end
        check({ph, ".grant"},     64'(grant),         64'(e_grant));
        check({ph, ".busy"},      64'(busy),          64'(g >= 0));
        check({ph, ".m_psel"},    64'(bus.m_psel),    64'(g >= 0));
        check({ph, ".m_penable"}, 64'(bus.m_penable), 64'(pen));
        check({ph, ".m_pwrite"},  64'(bus.m_pwrite),  64'(e_cmd.write));
        check({ph, ".m_pstrb"},   64'(bus.m_pstrb),   64'(e_cmd.strb));
        check({ph, ".m_paddr"},   64'(bus.m_paddr),   64'(e_cmd.addr));
        check({ph, ".m_pwdata"},  64'(bus.m_pwdata),  64'(e_cmd.wdata));
        check({ph, ".s_pready"},  64'(bus.s_pready),  64'(e_rdy));
        check({ph, ".s_pslverr"}, 64'(bus.s_pslverr), 64'(e_err));
        check({ph, ".s_prdata"},  64'(bus.s_prdata),  64'(e_rd));
        check({ph, ".to_pulse"},  64'(to_pulse),      64'(to));
    endtask

    // One full transfer starting in the IDLE cycle where arbitration happens.
    // waits = ACCESS/DRAIN cycles with m_pready low before the ready cycle.
    task automatic run_xfer(input int waits, input logic err, input logic [31:0] rd,
                            input bit drop_psel, input logic [NREQ-1:0] late_mask);
        int  g;
        bit  tmo;
        g = rr_pick(pending, last_win);
        @(negedge pclk);
        chk_bus("idle", -1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        step();
        last_win = g;
        raise(late_mask);
        @(negedge pclk);
        obs_grants.push_back(grant);
        chk_bus("setup", g, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        for (int c = 0; c <= waits; c++) begin
            step();
            if (drop_psel && c == 0) begin
                psel_drv[g] = 1'b0;
                apply();
            end
            bus.m_pready = (c == waits);
            if (c == waits) begin
                bus.m_pslverr = err;
                bus.m_prdata  = rd;
            end else begin
                bus.m_pslverr = 1'($urandom);
                bus.m_prdata  = $urandom;
            end
            tmo = (c == TIMEOUT - 1) && (c != waits);
            @(negedge pclk);
            if (c < TIMEOUT) begin
                chk_bus(tmo ? "timeout" : "access", g, 1'b1, (c == waits) || tmo,
                        (c == waits) ? err : 1'b1, (c == waits) ? rd : 32'h0, tmo);
            end else begin
                chk_bus("drain", g, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            end
        end

        step();
        pending[g]    = 1'b0;
        psel_drv[g]   = 1'b0;
        bus.m_pready  = 1'b0;
        bus.m_pslverr = 1'b0;
        bus.m_prdata  = '0;
        apply();
    endtask

    // Watchdog: the bench never waits on DUT events, but guard anyway.
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apb_cmd_t          c;
        logic [8*NREQ-1:0] seq;
        int                w;

        // Reset state.
        preset_b = 1'b0;
        pending  = '0;
        psel_drv = '0;
        last_win = NREQ - 1;
        for (int i = 0; i < NREQ; i++) r_cmd[i] = '0;
        apply();
        bus.m_pready  = 1'b0;
        bus.m_pslverr = 1'b0;
        bus.m_prdata  = '0;
        repeat (3) @(negedge pclk);
        chk_bus("reset", -1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #2 preset_b = 1'b1;
        step();
        @(negedge pclk);
        chk_bus("post_reset", -1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();

        // Contention from reset: grants must alternate 0,1,0,1.
        obs_grants.delete();
        raise(2'b11);
        run_xfer(1, 1'b0, 32'h1111_0000, 1'b0, '0);
        run_xfer(0, 1'b0, 32'h2222_0000, 1'b0, '0);
        raise(2'b11);
        run_xfer(2, 1'b0, 32'h3333_0000, 1'b0, '0);
        run_xfer(1, 1'b0, 32'h4444_0000, 1'b0, '0);
        seq = '0;
        for (int i = 0; i < 4; i++) seq = {seq[8*NREQ-NREQ-1:0], obs_grants[i]};
        check("rr_sequence", 64'(seq), 64'(8'b01_10_01_10));

        // Single write from requester 0, ready on the 4th ACCESS cycle.
        c.write = 1'b1;
        c.strb  = 4'hF;
        c.addr  = 26'h0001234;
        c.wdata = 32'hDEADBEEF;
        raise_cmd(0, c);
        run_xfer(3, 1'b0, 32'h0, 1'b0, '0);

        // Read with slave error on requester 1.
        c.write = 1'b0;
        c.strb  = 4'h0;
        c.addr  = 26'h2ABCDEF;
        c.wdata = 32'h0;
        raise_cmd(1, c);
        run_xfer(2, 1'b1, 32'hA5A5A5A5, 1'b0, '0);

        // Timeout with both waiting, then the other requester gets the next grant.
        raise(2'b11);
        run_xfer(20, 1'b0, 32'hBAD0_BAD0, 1'b0, '0);
        // Ready arriving in exactly the timeout cycle completes normally.
        run_xfer(TIMEOUT - 1, 1'b1, 32'h0F0F_0F0F, 1'b0, '0);
        // Ready exactly one cycle after the timeout: shortest drain.
        raise(2'b01);
        run_xfer(TIMEOUT, 1'b0, 32'h1234_5678, 1'b0, '0);

        // Granted requester drops psel mid-transfer; transfer still completes.
        raise(2'b10);
        run_xfer(3, 1'b0, 32'hCAFE_F00D, 1'b1, '0);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            if (pending == '0) raise(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
            else               raise(NREQ'($urandom));
            w = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 6)
                                            : $urandom_range(0, 4);
            run_xfer(w, 1'($urandom), $urandom, ($urandom_range(0, 7) == 0),
                     NREQ'($urandom));
        end
        while (pending != '0) run_xfer($urandom_range(0, 2), 1'b0, $urandom, 1'b0, '0);

        // Reset asserted in ACCESS: outputs drop at once, requester 0 wins next.
        raise(2'b10);
        w = rr_pick(pending, last_win);
        @(negedge pclk);
        chk_bus("pre_rst_idle", -1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        @(negedge pclk);
        chk_bus("pre_rst_setup", w, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        bus.m_pready = 1'b0;
        @(negedge pclk);
        chk_bus("pre_rst_access", w, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        #2 preset_b = 1'b0;
        #1;
        chk_bus("mid_reset", -1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        pending  = '0;
        psel_drv = '0;
        apply();
        last_win = NREQ - 1;
        @(negedge pclk);
        #2 preset_b = 1'b1;
        step();
        obs_grants.delete();
        raise(2'b11);
        run_xfer(1, 1'b0, 32'h5555_AAAA, 1'b0, '0);
        check("rst_first_grant", 64'(obs_grants[0]), 64'(2'b01));
        while (pending != '0) run_xfer(0, 1'b0, $urandom, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
